// File: rtl/regfile_sb_pkg.sv
// Shared widths, enable levels and the zero word for the scoreboarded register file.
package regfile_sb_pkg;
   localparam int REG_BUS_W      = 32;
   localparam int REG_ADDR_BUS_W = 5;
   localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;
   localparam logic WRITE_ENABLE = 1'b1;
   localparam logic READ_ENABLE  = 1'b1;
   localparam logic RST_ACTIVE   = 1'b0;
endpackage

// File: rtl/regfile_rdport.sv
// One read port: zero/disable check, same-cycle write bypass, storage and busy lookup.
module regfile_rdport import regfile_sb_pkg::*; #(
   parameter int DATA_W = REG_BUS_W,
   parameter int ADDR_W = REG_ADDR_BUS_W,
   parameter int N_WR   = 2
) (
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     re,
   input  logic [ADDR_W-1:0]        raddr,
   input  logic [N_WR-1:0]          we,
   input  logic [N_WR*ADDR_W-1:0]   waddr,
   input  logic [N_WR*DATA_W-1:0]   wdata,
   input  logic [DATA_W-1:0]        reg_data,
   input  logic                     reg_busy,
   output logic [DATA_W-1:0]        rdata,
   output logic                     rbusy
);

   always_comb begin
      rdata = DATA_W'(ZERO_WORD);
      rbusy = 1'b0;
      if (rst != RST_ACTIVE && re == READ_ENABLE && raddr != '0) begin
         rdata = reg_data;
         rbusy = reg_busy;
         // Ascending scan so the highest-index matching writer is the one that sticks.
         if (rdy) begin
            for (int k = 0; k < N_WR; k++) begin
               if (we[k] == WRITE_ENABLE && waddr[k*ADDR_W +: ADDR_W] == raddr) begin
                  rdata = wdata[k*DATA_W +: DATA_W];
                  rbusy = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a one-bit-per-register busy scoreboard and write bypass.
module regfile_sb import regfile_sb_pkg::*; #(
   parameter int DATA_W = REG_BUS_W,
   parameter int ADDR_W = REG_ADDR_BUS_W,
   parameter int N_RD   = 2,
   parameter int N_WR   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic [N_WR-1:0]          we,
   input  logic [N_WR*ADDR_W-1:0]   waddr,
   input  logic [N_WR*DATA_W-1:0]   wdata,
   input  logic [N_RD-1:0]          re,
   input  logic [N_RD*ADDR_W-1:0]   raddr,
   output logic [N_RD*DATA_W-1:0]   rdata,
   output logic [N_RD-1:0]          rbusy,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic                     flush
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (rdy) begin
         for (int k = 0; k < N_WR; k++) begin
            if (we[k] == WRITE_ENABLE && waddr[k*ADDR_W +: ADDR_W] != '0) begin
               regs_d[waddr[k*ADDR_W +: ADDR_W]] = wdata[k*DATA_W +: DATA_W];
               busy_d[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
         end
         // Issue applies after writeback clears: a newer writer keeps the register busy.
         if (flush)
            busy_d = '0;
         else if (iss_en && iss_addr != '0)
            busy_d[iss_addr] = 1'b1;
      end
      regs_d[0] = DATA_W'(ZERO_WORD);
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= DATA_W'(ZERO_WORD);
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   for (genvar j = 0; j < N_RD; j++) begin : g_rd
      regfile_rdport #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .N_WR   (N_WR)
      ) u_rdport (
         .rst      (rst),
         .rdy      (rdy),
         .re       (re[j]),
         .raddr    (raddr[j*ADDR_W +: ADDR_W]),
         .we       (we),
         .waddr    (waddr),
         .wdata    (wdata),
         .reg_data (regs_q[raddr[j*ADDR_W +: ADDR_W]]),
         .reg_busy (busy_q[raddr[j*ADDR_W +: ADDR_W]]),
         .rdata    (rdata[j*DATA_W +: DATA_W]),
         .rbusy    (rbusy[j])
      );
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized scenarios for regfile_sb; expectations go through a scoreboard queue.
module tb_regfile_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             rdy;
   logic [NW-1:0]    we;
   logic [NW*AW-1:0] waddr;
   logic [NW*DW-1:0] wdata;
   logic [NR-1:0]    re;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]    rbusy;
   logic             iss_en;
   logic [AW-1:0]    iss_addr;
   logic             flush;

   typedef struct {
      string       name;
      int          port;
      logic [DW-1:0] data;
      logic        busy;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_WR(NW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = '0; iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rdy = 1'b1; re = '1;
   endtask

   task automatic set_wr(input int k, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[k] = en;
      waddr[k*AW +: AW] = a;
      wdata[k*DW +: DW] = d;
   endtask

   task automatic set_rd(input int j, input logic en, input logic [AW-1:0] a);
      re[j] = en;
      raddr[j*AW +: AW] = a;
   endtask

   task automatic push(input string n, input int p, input logic [DW-1:0] d, input logic b);
      exp_t x;
      x.name = n; x.port = p; x.data = d; x.busy = b;
      sb.push_back(x);
   endtask

   task automatic test_reset();
      rst = 1'b0; idle(); waddr = '0; wdata = '0; raddr = '0;
      tick();
      rst = 1'b1;
      set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      iss_en = 1'b1; iss_addr = 5'd5;
      tick();
      idle(); set_rd(0, 1'b1, 5'd5);
      push("reset_pre_r5", 0, 32'hDEAD_BEEF, 1'b1);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      rst = 1'b0;
      set_rd(1, 1'b1, 5'd5); set_wr(0, 1'b1, 5'd5, 32'h1234_5678);
      push("reset_async_p0", 0, '0, 1'b0);
      push("reset_async_bypass_p1", 1, '0, 1'b0);
      #1;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      tick();
      idle(); rst = 1'b1;
      tick();
      push("reset_post_r5", 0, '0, 1'b0);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
   endtask

   task automatic test_dual_write();
      idle();
      set_wr(0, 1'b1, 5'd3, 32'h11); set_wr(1, 1'b1, 5'd3, 32'h22);
      set_rd(0, 1'b1, 5'd3); set_rd(1, 1'b0, 5'd3);
      push("dual_bypass_r3", 0, 32'h22, 1'b0);
      push("dual_re_off", 1, '0, 1'b0);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      tick();
      idle(); set_rd(1, 1'b1, 5'd3);
      push("dual_store_r3", 1, 32'h22, 1'b0);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
   endtask

   task automatic test_scoreboard();
      idle(); iss_en = 1'b1; iss_addr = 5'd7;
      set_rd(0, 1'b1, 5'd7);
      push("sb_busy_not_yet", 0, '0, 1'b0);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      tick();
      idle();
      push("sb_busy_r7", 0, '0, 1'b1);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      set_wr(1, 1'b1, 5'd7, 32'h55);
      push("sb_wb_bypass_r7", 0, 32'h55, 1'b0);
      #1;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      tick();
      idle();
      push("sb_cleared_r7", 0, 32'h55, 1'b0);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
   endtask

   task automatic test_collision();
      idle();
      set_wr(0, 1'b1, 5'd9, 32'hA5A5_0009);
      iss_en = 1'b1; iss_addr = 5'd9;
      set_rd(1, 1'b1, 5'd9);
      push("coll_bypass_r9", 1, 32'hA5A5_0009, 1'b0);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      tick();
      idle();
      push("coll_set_wins_r9", 1, 32'hA5A5_0009, 1'b1);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
   endtask

   task automatic test_flush();
      idle();
      iss_en = 1'b1; iss_addr = 5'd1; tick();
      iss_addr = 5'd2; tick();
      iss_addr = 5'd4; tick();
      idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
      set_rd(0, 1'b1, 5'd2); set_rd(1, 1'b1, 5'd4);
      push("flush_pre_r2", 0, '0, 1'b1);
      push("flush_pre_r4", 1, '0, 1'b1);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      tick();
      idle();
      set_rd(0, 1'b1, 5'd1); set_rd(1, 1'b1, 5'd6);
      push("flush_r1", 0, '0, 1'b0);
      push("flush_over_iss_r6", 1, '0, 1'b0);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      set_rd(0, 1'b1, 5'd2); set_rd(1, 1'b1, 5'd4);
      push("flush_r2", 0, '0, 1'b0);
      push("flush_r4", 1, '0, 1'b0);
      #1;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
   endtask

   task automatic test_r0_rdy();
      idle();
      set_wr(0, 1'b1, 5'd0, 32'hFFFF); iss_en = 1'b1; iss_addr = 5'd0;
      set_rd(0, 1'b1, 5'd0);
      push("r0_bypass", 0, '0, 1'b0);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      tick();
      idle();
      push("r0_store", 0, '0, 1'b0);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      rdy = 1'b0;
      set_wr(0, 1'b1, 5'd8, 32'h99); iss_en = 1'b1; iss_addr = 5'd8;
      set_rd(0, 1'b1, 5'd8); set_rd(1, 1'b1, 5'd3);
      push("rdy0_no_bypass_r8", 0, '0, 1'b0);
      push("rdy0_read_valid_r3", 1, 32'h22, 1'b0);
      #1;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
      tick(); tick();
      idle();
      tick();
      push("rdy0_r8_unchanged", 0, '0, 1'b0);
      #2;
      while (sb.size() != 0) begin e = sb.pop_front(); checks++;
         if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
            $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] mem [2**AW];
      logic [2**AW-1:0] bsy;
      logic [DW-1:0] d;
      logic b;
      logic [AW-1:0] ra, wa;
      idle(); rst = 1'b0;
      #1;
      rst = 1'b1;
      for (int i = 0; i < 2**AW; i++) mem[i] = '0;
      bsy = '0;
      tick();
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < NW; k++)
            set_wr(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom());
         for (int j = 0; j < NR; j++)
            set_rd(j, 1'($urandom_range(0, 7) != 0), AW'($urandom_range(0, 15)));
         iss_en = 1'($urandom_range(0, 1));
         iss_addr = AW'($urandom_range(0, 15));
         flush = 1'($urandom_range(0, 15) == 0);
         rdy = 1'($urandom_range(0, 7) != 0);
         for (int j = 0; j < NR; j++) begin
            ra = raddr[j*AW +: AW];
            d = '0; b = 1'b0;
            if (re[j] && ra != '0) begin
               d = mem[ra]; b = bsy[ra];
               if (rdy)
                  for (int k = 0; k < NW; k++)
                     if (we[k] && waddr[k*AW +: AW] == ra) begin d = wdata[k*DW +: DW]; b = 1'b0; end
            end
            push($sformatf("rand_c%0d_p%0d", c, j), j, d, b);
         end
         #2;
         while (sb.size() != 0) begin e = sb.pop_front(); checks++;
            if ({rdata[e.port*DW +: DW], rbusy[e.port]} !== {e.data, e.busy}) begin errors++;
               $display("FAIL %s: rdata/rbusy=%h/%b expected %h/%b", e.name, rdata[e.port*DW +: DW], rbusy[e.port], e.data, e.busy); end
         end
         if (rdy) begin
            for (int k = 0; k < NW; k++) begin
               wa = waddr[k*AW +: AW];
               if (we[k] && wa != '0) begin mem[wa] = wdata[k*DW +: DW]; bsy[wa] = 1'b0; end
            end
            if (flush) bsy = '0;
            else if (iss_en && iss_addr != '0) bsy[iss_addr] = 1'b1;
         end
         tick();
      end
      idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_dual_write();
      test_scoreboard();
      test_collision();
      test_flush();
      test_r0_rdy();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
